// File: rtl/axi_pkg.sv
// AXI burst/response encodings and the read responder state encoding.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA
  } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    step = ADDR_W'(1) << size;
    span = step * (ADDR_W'(len) + ADDR_W'(1));
    incr = addr + step;
    next_addr = addr;
    unique case (1'b1)
      burst == BURST_INCR: next_addr = incr;
      burst == BURST_WRAP:
        next_addr = (addr & ~(span - ADDR_W'(1)))
                  | (incr & (span - ADDR_W'(1)));
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder: one burst at a time from a
// synchronous single-port memory, two cycles per beat.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         OFF_W    = $clog2(DATA_W / 8);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  state_t            state;
  state_t            next;
  logic              arready_q;
  logic              fresh;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        len_q;
  logic [7:0]        beat;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [1:0]        resp_q;
  logic [1:0]        ar_resp;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] off;
  logic              ar_hs;
  logic              last;
  logic              len_ok;
  logic              slverr;
  logic              decerr;
  logic              unused_prot;

  assign unused_prot = ^ARPROT;
  assign ar_hs       = ARVALID && arready_q;
  assign last        = beat == len_q;
  assign ARREADY     = arready_q;
  assign mem_addr    = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};

  // Error class is fixed for the whole burst at the AR handshake.
  always_comb begin
    step   = ADDR_W'(1) << ARSIZE;
    off    = ARADDR - MEM_BASE;
    len_ok = ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15};
    slverr = (ARSIZE > MAX_SIZE)
          || (ARBURST == BURST_RSVD)
          || (ARBURST == BURST_WRAP && !len_ok)
          || (ARBURST == BURST_WRAP
              && (ARADDR & (step - ADDR_W'(1))) != '0);
    decerr = off >= MEM_SIZE;
    if (slverr)      ar_resp = RESP_SLVERR;
    else if (decerr) ar_resp = RESP_DECERR;
    else             ar_resp = RESP_OKAY;
  end

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr     (addr_q),
    .size     (size_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(addr_nxt)
  );

  always_comb begin
    next   = state;
    mem_en = 1'b0;
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = RESP_OKAY;
    RDATA  = '0;
    unique case (state)
      ST_IDLE: begin
        if (ar_hs) next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_en = resp_q == RESP_OKAY;
        next   = ST_DATA;
      end
      ST_DATA: begin
        RVALID = 1'b1;
        RLAST  = last;
        RRESP  = resp_q;
        // memory word arrives on the first DATA cycle, held after
        if (resp_q == RESP_OKAY) RDATA = fresh ? mem_rdata : rdata_q;
        if (RREADY) next = last ? ST_IDLE : ST_FETCH;
      end
      default: next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      arready_q <= 1'b0;
      fresh     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      resp_q    <= RESP_OKAY;
      beat      <= '0;
    end else begin
      state     <= next;
      arready_q <= next == ST_IDLE;
      fresh     <= state == ST_FETCH;
      if (state == ST_DATA && fresh) rdata_q <= mem_rdata;
      if (ar_hs) begin
        addr_q  <= ARADDR;
        len_q   <= ARLEN;
        size_q  <= ARSIZE;
        burst_q <= ARBURST;
        resp_q  <= ar_resp;
        beat    <= '0;
      end
      if (state == ST_DATA && RREADY && !last) begin
        addr_q <= addr_nxt;
        beat   <= beat + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder against a burst-level model.
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;

  int total = 0;
  int passed = 0;
  logic [31:0] memq[$];

  always #5 ACLK = ~ACLK;

  axi_read_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] word_at(logic [31:0] a);
    return 64'h1111_0000_0000_0000 + 64'((a - BASE) >> 3);
  endfunction

  always @(posedge ACLK) if (mem_en) mem_rdata <= word_at(mem_addr);
  always @(negedge ACLK) if (mem_en) memq.push_back(mem_addr);

  function automatic logic [1:0] exp_resp(logic [31:0] a, logic [7:0] len,
                                          logic [2:0] sz, logic [1:0] b);
    longint s  = longint'(1) << sz;
    longint av = longint'(a);
    bit wrap_bad, slv, dec;
    wrap_bad = !(len == 1 || len == 3 || len == 7 || len == 15)
            || (av % s) != 0;
    slv = sz > 3 || b == 2'b11 || (b == 2'b10 && wrap_bad);
    dec = av < longint'(BASE) || av >= longint'(BASE) + longint'(SIZE);
    if (slv) return 2'b10;
    if (dec) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_addr(logic [31:0] a, logic [7:0] len,
                                           logic [2:0] sz, logic [1:0] b,
                                           int k);
    longint s    = longint'(1) << sz;
    longint span = s * (longint'(len) + 1);
    longint av   = longint'(a);
    longint lo;
    case (b)
      2'b01: return 32'(av + longint'(k) * s);
      2'b10: begin
        lo = av - (av % span);
        return 32'(lo + ((av - lo) + longint'(k) * s) % span);
      end
      default: return a;
    endcase
  endfunction

  task automatic run_burst(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] b,
                           input bit rnd_ready, input int stall_beat,
                           input int stall_len, input bit chk_lat);
    logic [1:0]  er;
    logic [31:0] ea;
    logic [63:0] ed;
    int n, beat, cyc, stalled;
    bit ok;
    er = exp_resp(a, len, sz, b);
    n = 0; beat = 0; cyc = 0; stalled = 0;
    memq.delete();
    RREADY = 1'b0;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    total++;
    if (ARREADY !== 1'b1) $display("FAIL ar_wait got=%b want=1", ARREADY);
    else passed++;
    ARVALID = 1'b1; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = b;
    ARPROT = 3'($urandom);
    @(negedge ACLK);
    ARVALID = 1'b0; ARADDR = $urandom; ARLEN = 8'($urandom);
    ARSIZE = 3'($urandom); ARBURST = 2'($urandom);
    if (chk_lat) begin
      total++;
      if (mem_en !== (er == 2'b00) || RVALID !== 1'b0)
        $display("FAIL lat_fetch mem_en=%b rvalid=%b want=%b/0",
                 mem_en, RVALID, er == 2'b00);
      else passed++;
    end
    while (beat <= int'(len) && cyc < 400) begin
      if (chk_lat && cyc == 1) begin
        total++;
        if (RVALID !== 1'b1) $display("FAIL lat_data rvalid=%b want=1", RVALID);
        else passed++;
      end
      if (RVALID && beat == stall_beat && stalled < stall_len) begin
        RREADY = 1'b0;
        stalled++;
      end else begin
        RREADY = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (RVALID) begin
        ea = exp_addr(a, len, sz, b, beat) & ~32'h7;
        ed = (er == 2'b00) ? word_at(ea) : 64'h0;
        total++;
        if (RDATA !== ed || RRESP !== er || RLAST !== (beat == int'(len)))
          $display("FAIL beat%0d data=%h resp=%b last=%b want %h/%b/%b",
                   beat, RDATA, RRESP, RLAST, ed, er, beat == int'(len));
        else passed++;
        if (RREADY) beat++;
      end
      @(negedge ACLK);
      cyc++;
    end
    RREADY = 1'b0;
    total++;
    if (beat <= int'(len)) $display("FAIL beats got=%0d want=%0d", beat, len + 1);
    else passed++;
    total++;
    if (ARREADY !== 1'b1) $display("FAIL ar_after got=%b want=1", ARREADY);
    else passed++;
    ok = 1'b1;
    if (er != 2'b00) ok = memq.size() == 0;
    else begin
      ok = memq.size() == int'(len) + 1;
      for (int i = 0; i < memq.size() && ok; i++)
        if (memq[i] !== (exp_addr(a, len, sz, b, i) & ~32'h7)) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL mem_addrs count=%0d want=%0d resp=%b",
                      memq.size(), er == 2'b00 ? int'(len) + 1 : 0, er);
    else passed++;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    total++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0 || RLAST !== 1'b0
        || RDATA !== 64'h0 || RRESP !== 2'b00 || mem_en !== 1'b0)
      $display("FAIL reset_state ar=%b rv=%b rl=%b rd=%h rr=%b en=%b want 0s",
               ARREADY, RVALID, RLAST, RDATA, RRESP, mem_en);
    else passed++;
    ARESET = 1'b0;
    @(negedge ACLK);
    total++;
    if (ARREADY !== 1'b1) $display("FAIL reset_release ar=%b want=1", ARREADY);
    else passed++;
  endtask

  task automatic test_single();
    run_burst(BASE, 8'd0, 3'd3, BURST_INCR, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_incr_stall();
    run_burst(BASE + 32'h10, 8'd3, 3'd3, BURST_INCR, 1'b0, 1, 3, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst(BASE + 32'h18, 8'd3, 3'd3, BURST_WRAP, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_errors();
    run_burst(BASE, 8'd1, 3'd4, BURST_INCR, 1'b0, -1, 0, 1'b1);
    run_burst(32'h0000_1000, 8'd0, 3'd3, BURST_INCR, 1'b0, -1, 0, 1'b1);
    run_burst(BASE + 32'h8, 8'd2, 3'd3, BURST_WRAP, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_fixed();
    run_burst(BASE + 32'h8, 8'd2, 3'd3, BURST_FIXED, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int seen = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    ARVALID = 1'b1; ARADDR = BASE + 32'h40; ARLEN = 8'd7;
    ARSIZE = 3'd3; ARBURST = BURST_INCR; RREADY = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0;
    while (n < 50) begin
      if (RVALID) seen++;
      if (seen == 2) break;
      @(negedge ACLK);
      n++;
    end
    total++;
    if (seen != 2) $display("FAIL mid_beats got=%0d want=2", seen);
    else passed++;
    ARESET = 1'b1;
    @(negedge ACLK);
    total++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL mid_reset rv=%b rl=%b en=%b want 000", RVALID, RLAST, mem_en);
    else passed++;
    ARESET = 1'b0;
    RREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (ARREADY !== 1'b1) $display("FAIL mid_release ar=%b want=1", ARREADY);
    else passed++;
    run_burst(BASE + 32'h28, 8'd0, 3'd3, BURST_INCR, 1'b0, -1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  b;
    for (int i = 0; i < 25; i++) begin
      sz = 3'($urandom_range(0, 4));
      b  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 1023) << 3) + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      if (b == BURST_WRAP && $urandom_range(0, 3) != 0)
        len = 8'((2 << $urandom_range(0, 3)) - 1);
      else len = 8'($urandom_range(0, 9));
      run_burst(a, len, sz, b, 1'b1, -1, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap();
    test_errors();
    test_fixed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel responder (slave side) serving burst reads from a synchronous single-port memory.
- Accepts one AR request at a time and returns ARLEN+1 beats on the R channel with RLAST on the final beat.
- Sits between the core's AXI read initiators (instruction/data fetch) and the on-chip RAM model, and replaces the behavioural memory path.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (power of two, ≥ 32)
MEM_BASE, 32'h8000_0000, first decoded byte address
MEM_SIZE, 32'h0800_0000, decoded range in bytes

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  synchronous, active-high reset
ARVALID  in  1  read request valid
ARREADY  out  1  responder can accept a request
ARADDR  in  ADDR_W  start byte address
ARLEN  in  8  beats minus one
ARSIZE  in  3  log2(bytes per beat)
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARPROT  in  3  accepted and ignored
RVALID  out  1  read data valid
RREADY  in  1  initiator accepts data
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
RLAST  out  1  final beat of burst
mem_en  out  1  memory read strobe
mem_addr  out  ADDR_W  word-aligned byte address (low log2(DATA_W/8) bits zero)
mem_rdata  in  DATA_W  memory data, valid one cycle after mem_en

Behaviour:
- Reset (ARESET high at a clock edge): state IDLE. ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=00, mem_en=0, and beat counter cleared. Reset mid-burst aborts the burst with no further beats.
- ARREADY is registered and equals 1 only in IDLE, which includes the first cycle after reset release.
- FSM states:
  - IDLE:
    - On ARVALID&&ARREADY, latch addr, len, size, burst and the error class, then go to FETCH.
  - FETCH:
    - For OKAY, assert mem_en for one cycle with mem_addr = aligned current addr.
    - For errors, assert no mem_en.
    - Next state is DATA.
  - DATA:
    - RVALID=1, RDATA = mem_rdata captured at DATA entry (0 for errors), RRESP = latched class, RLAST = (beat==len).
    - RVALID, RDATA, RRESP and RLAST hold stable while RREADY=0.
    - On RVALID&&RREADY with !RLAST: advance addr and beat, then go to FETCH.
    - On RVALID&&RREADY with RLAST: go to IDLE.
- Timing:
  - Latency: AR handshake at edge t, mem_en high in cycle t+1, RVALID high in cycle t+2.
  - Throughput is one beat per 2 cycles with RREADY held high.
  - A new AR request can be accepted in the cycle after the final handshake.
- Address generation (size bytes S = 1<<ARSIZE):
  - FIXED: addr unchanged.
  - INCR: addr += S; wraps modulo 2^ADDR_W with no error.
  - WRAP: boundary B = S*(len+1). addr = (addr & ~(B-1)) | ((addr+S) & (B-1)).
- Error classes (decided once at AR handshake, applied to all beats):
  - SLVERR if any of:
    - ARSIZE > log2(DATA_W/8);
    - ARBURST==11;
    - WRAP with len not in {1,3,7,15};
    - WRAP with ARADDR not S-aligned.
  - DECERR if ARADDR is outside [MEM_BASE, MEM_BASE+MEM_SIZE). SLVERR takes priority over DECERR.
  - Error bursts still return exactly len+1 beats with RDATA=0.
- Narrow transfers return the full aligned word with no lane shifting; the initiator selects bytes.
- ARVALID asserted outside IDLE is ignored (ARREADY=0). Initiator values sampled only at the handshake edge.

Decomposition:
- Package axi_pkg:
  - burst constants BURST_FIXED/INCR/WRAP;
  - response constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - FSM state encoding for IDLE/FETCH/DATA.
- One sub-module, axi_burst_addr_gen: combinational next-address computation from addr, size, len and burst. Unit-testable on its own.

Test Plan:
- Memory preloaded with word[i] = 64'h1111_0000_0000_0000 + i.
  - ARADDR=0x8000_0000, ARLEN=0, ARSIZE=3, INCR, RREADY=1 -> RVALID at t+2, RDATA=0x1111_0000_0000_0000, RRESP=00, RLAST=1, ARREADY back to 1 the cycle after.
- 4-beat INCR from 0x8000_0010, size 3, RREADY low for 3 cycles on beat 2 -> mem_addr 0x10, 0x18, 0x20, 0x28 (offsets). RDATA held stable during the stall. RLAST only on beat 4.
- WRAP, len=3, size 3, ARADDR=0x8000_0018 -> mem_addr offsets 0x18, 0x00, 0x08, 0x10.
- Error responses:
  - ARSIZE=4 (16 B on 64-bit bus), ARLEN=1 -> two beats with RRESP=10 and RDATA=0, mem_en never asserted.
  - ARADDR=0x0000_1000, ARLEN=0 -> one beat with RRESP=11.
- Reset asserted during beat 2 of an 8-beat burst -> next cycle RVALID=0, RLAST=0, mem_en=0. After release, ARREADY=1 and a fresh single-beat read returns correct data.
- FIXED, len=2, ARADDR=0x8000_0008 -> three beats, all mem_addr offset 0x08, RLAST on the third.
